hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline control for the SIMPLE 5-stage core: resolves every hazard the forwarding path cannot.
  - Load-use: the load result does not exist until after p3.
  - Taken-branch flush.
  - Multi-cycle data-memory wait.
- Drives stage write-enables, bubble and flush controls, plus a saturating stall counter and a sticky memory-timeout flag.
- Sits beside the forwarding logic. It consumes the same 3-bit register numbers and write-enables, but acts on the stall/flush side rather than the operand-mux side.

Parameters:
CNT_W, 16, width of stall_cnt (saturating)
MAX_WAIT, 255, memory-wait cycles tolerated before mem_timeout sets (1..2^16-1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_RegRs  in  3  source register A of instruction in ID (p1)
id_RegRt  in  3  source register B of instruction in ID (p1)
id_UseRs  in  1  ID instruction actually reads RegRs
id_UseRt  in  1  ID instruction actually reads RegRt
p2_RegRd  in  3  destination register of instruction in EX (p2)
p2_RegWren  in  1  p2 instruction writes a register
p2_MemRead  in  1  p2 instruction is a load
branch_taken  in  1  p3 resolved a taken branch/jump this cycle
mem_req  in  1  p3 instruction accesses data memory this cycle
mem_ready  in  1  data memory completes the p3 access this cycle
pc_wren  out  1  PC update enable
p1_wren  out  1  IF/ID register enable
p1_flush  out  1  IF/ID register loads NOP
p2_bubble  out  1  ID/EX register loads NOP (control bits zero)
p3_hold  out  1  EX/MEM and MEM/WB registers hold; p4 write-back suppressed
stall_cnt  out  CNT_W  total stall cycles since reset, saturating
mem_timeout  out  1  sticky: a memory wait exceeded MAX_WAIT

Behaviour:
Reset:
- rst_n low forces these values immediately (asynchronous): state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0.
- While rst_n is low: pc_wren=0, p1_wren=0, p1_flush=0, p2_bubble=1, p3_hold=0.

States:
- RUN: normal issue.
- MEM_WAIT: waiting for mem_ready.

Controls are combinational from the registered state and the current inputs (same-cycle stall). The state, wait_cnt, stall_cnt and mem_timeout registers are updated on the clock edge.

Derived signals:
- memstall = mem_req & ~mem_ready
- luhaz = p2_MemRead & p2_RegWren & ((id_UseRs & p2_RegRd==id_RegRs) | (id_UseRt & p2_RegRd==id_RegRt))
- Register 0 receives no special treatment; matching is purely numeric.

Priority, evaluated each cycle in either state (memstall > branch > load-use > none):
- memstall:
  - Outputs: pc_wren=0, p1_wren=0, p1_flush=0, p2_bubble=0, p3_hold=1.
  - Next state MEM_WAIT; wait_cnt increments, saturating at MAX_WAIT.
  - If wait_cnt==MAX_WAIT while still memstall, mem_timeout sets.
  - branch_taken and luhaz are ignored this cycle; they re-present once p3 is released.
- else branch_taken:
  - Outputs: pc_wren=1, p1_wren=1, p1_flush=1, p2_bubble=1, p3_hold=0.
  - The flush dominates luhaz.
- else luhaz:
  - Outputs: pc_wren=0, p1_wren=0, p1_flush=0, p2_bubble=1, p3_hold=0.
  - Exactly one stall per load; the next cycle p2 holds a bubble, so luhaz clears by construction.
- else:
  - Outputs: pc_wren=1, p1_wren=1, p1_flush=0, p2_bubble=0, p3_hold=0.

Leaving MEM_WAIT:
- The first cycle with ~memstall returns the next state to RUN and clears wait_cnt.
- That completion cycle is treated as an ordinary RUN cycle: branch and load-use rules apply with zero added latency.

stall_cnt:
- +1 in every cycle where pc_wren=0 and rst_n is high; a branch flush does not count.
- Saturates at 2^CNT_W-1 and never wraps.

mem_timeout:
- Cleared only by reset. Control outputs are unaffected; waiting continues indefinitely.

Test Plan:
1. Reset release with idle inputs -> the first cycle after reset shows pc_wren=1, p1_wren=1, p2_bubble=0, stall_cnt=0, mem_timeout=0.
2. Load-use: p2_MemRead=1, p2_RegWren=1, p2_RegRd=3, id_RegRt=3, id_UseRt=1 for one cycle, then a bubble in p2 -> exactly one cycle of pc_wren=0, p1_wren=0, p2_bubble=1; stall_cnt=1.
   - Repeat with id_UseRt=0 -> no stall.
3. Branch and load-use in the same cycle: branch_taken=1 with luhaz true -> p1_flush=1, p2_bubble=1, pc_wren=1; stall_cnt unchanged.
4. Memory wait: mem_req=1 with mem_ready low for 4 cycles, then high -> p3_hold=1 and pc_wren=0 for 4 cycles; the 5th cycle has p3_hold=0; stall_cnt=4; state back to RUN.
   - Asserting branch_taken during the wait is ignored until the release cycle, where it flushes.
5. Timeout: MAX_WAIT=3, mem_ready held low for 6 cycles -> mem_timeout rises after the 4th stalled cycle and stays 1 after mem_ready.
   - Asserting rst_n low mid-wait immediately clears mem_timeout and stall_cnt and forces p2_bubble=1.
6. Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_cnt stops at 15 and does not wrap.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: hazard-detection inputs and stage-control outputs between pipeline and stall unit
interface hazard_stall_unit_if;
  logic [2:0] id_RegRs;
  logic [2:0] id_RegRt;
  logic       id_UseRs;
  logic       id_UseRt;
  logic [2:0] p2_RegRd;
  logic       p2_RegWren;
  logic       p2_MemRead;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_wren;
  logic       p1_wren;
  logic       p1_flush;
  logic       p2_bubble;
  logic       p3_hold;
  modport master (
    output id_RegRs, id_RegRt, id_UseRs, id_UseRt, p2_RegRd, p2_RegWren, p2_MemRead,
           branch_taken, mem_req, mem_ready,
    input  pc_wren, p1_wren, p1_flush, p2_bubble, p3_hold
  );
  modport slave (
    input  id_RegRs, id_RegRt, id_UseRs, id_UseRt, p2_RegRd, p2_RegWren, p2_MemRead,
           branch_taken, mem_req, mem_ready,
    output pc_wren, p1_wren, p1_flush, p2_bubble, p3_hold
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall, branch flush and memory-wait hold for the 5-stage pipeline
module hazard_stall_unit #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave hz,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               mem_timeout
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [15:0] MW = 16'(MAX_WAIT);
  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             memstall, luhaz, run_pc, run_bub, run_flush;
  // hazard detection and priority: memory wait beats branch flush beats load-use
  always_comb begin
    memstall  = hz.mem_req & ~hz.mem_ready;
    luhaz     = hz.p2_MemRead & hz.p2_RegWren &
                ((hz.id_UseRs & (hz.p2_RegRd == hz.id_RegRs)) |
                 (hz.id_UseRt & (hz.p2_RegRd == hz.id_RegRt)));
    run_pc    = ~memstall & (hz.branch_taken | ~luhaz);
    run_flush = ~memstall & hz.branch_taken;
    run_bub   = ~memstall & (hz.branch_taken | luhaz);
  end
  // stage controls, forced to a safe bubble while reset is asserted
  always_comb begin
    hz.pc_wren   = rst_n & run_pc;
    hz.p1_wren   = rst_n & run_pc;
    hz.p1_flush  = rst_n & run_flush;
    hz.p2_bubble = ~rst_n | run_bub;
    hz.p3_hold   = rst_n & memstall;
  end
  // next state, saturating wait and stall counters, sticky timeout
  always_comb begin
    state_d       = memstall ? MEM_WAIT : RUN;
    wait_cnt_d    = ~memstall ? 16'd0 :
                    (state_q == RUN) ? 16'd1 :
                    (wait_cnt_q == MW) ? wait_cnt_q : wait_cnt_q + 16'd1;
    mem_timeout_d = mem_timeout_q | (memstall & (wait_cnt_q == MW));
    stall_cnt_d   = (run_pc | (&stall_cnt_q)) ? stall_cnt_q : stall_cnt_q + 1'b1;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  assign stall_cnt   = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vectors against default and small-parameter instances
module tb_hazard_stall_unit;
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0] rs = 0, rt = 0, rd = 0;
  logic use_rs = 0, use_rt = 0, wren = 0, mrd = 0, br = 0, mreq = 0, mrdy = 0;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        to_a, to_b;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  hazard_stall_unit_if hz_a ();
  hazard_stall_unit_if hz_b ();
  assign hz_a.id_RegRs = rs;    assign hz_b.id_RegRs = rs;
  assign hz_a.id_RegRt = rt;    assign hz_b.id_RegRt = rt;
  assign hz_a.id_UseRs = use_rs; assign hz_b.id_UseRs = use_rs;
  assign hz_a.id_UseRt = use_rt; assign hz_b.id_UseRt = use_rt;
  assign hz_a.p2_RegRd = rd;    assign hz_b.p2_RegRd = rd;
  assign hz_a.p2_RegWren = wren; assign hz_b.p2_RegWren = wren;
  assign hz_a.p2_MemRead = mrd; assign hz_b.p2_MemRead = mrd;
  assign hz_a.branch_taken = br; assign hz_b.branch_taken = br;
  assign hz_a.mem_req = mreq;   assign hz_b.mem_req = mreq;
  assign hz_a.mem_ready = mrdy; assign hz_b.mem_ready = mrdy;
  hazard_stall_unit u_a (.clk(clk), .rst_n(rst_n), .hz(hz_a), .stall_cnt(cnt_a), .mem_timeout(to_a));
  hazard_stall_unit #(.CNT_W(4), .MAX_WAIT(3)) u_b (.clk(clk), .rst_n(rst_n), .hz(hz_b), .stall_cnt(cnt_b), .mem_timeout(to_b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ctl(input string tag, input logic [4:0] exp);
    @(negedge clk);
    check(tag, {hz_a.pc_wren, hz_a.p1_wren, hz_a.p1_flush, hz_a.p2_bubble, hz_a.p3_hold}, exp);
  endtask
  task automatic load_use(input logic [2:0] d, input logic [2:0] s, input logic ur, input logic ut);
    mrd = 1; wren = 1; rd = d; rs = s; rt = s; use_rs = ur; use_rt = ut;
  endtask
  task automatic idle();
    mrd = 0; wren = 0; rd = 0; rs = 0; rt = 0; use_rs = 0; use_rt = 0; br = 0; mreq = 0; mrdy = 0;
  endtask
  initial begin
    #2;
    check("rst_ctl", {hz_a.pc_wren, hz_a.p1_wren, hz_a.p1_flush, hz_a.p2_bubble, hz_a.p3_hold}, 5'b00010);
    check("rst_cnt", cnt_a, 0);
    step();
    step();
    rst_n = 1;
    ctl("run_idle", 5'b11000);
    check("run_cnt", cnt_a, 0);
    check("run_to", to_a, 0);
    step();
    load_use(3, 3, 0, 1);
    ctl("lu_rt", 5'b00010);
    step();
    idle();
    ctl("lu_after", 5'b11000);
    check("lu_cnt", cnt_a, 1);
    step();
    load_use(3, 3, 0, 0);
    ctl("lu_nouse", 5'b11000);
    step();
    check("lu_nouse_cnt", cnt_a, 1);
    load_use(5, 5, 1, 0);
    ctl("lu_rs", 5'b00010);
    step();
    load_use(0, 0, 1, 0);
    ctl("lu_r0", 5'b00010);
    step();
    check("lu_r0_cnt", cnt_a, 3);
    load_use(3, 3, 0, 1);
    br = 1;
    ctl("br_lu", 5'b11110);
    step();
    check("br_cnt", cnt_a, 3);
    idle();
    mreq = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) br = 1;
      ctl($sformatf("mw_%0d", i), 5'b00001);
      step();
    end
    mrdy = 1;
    ctl("mw_rel_br", 5'b11110);
    step();
    idle();
    check("mw_cnt", cnt_a, 7);
    check("mw_state", 32'(u_a.state_q), 0);
    check("mw_to_a", to_a, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    mreq = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("to_%0d", i), to_b, (i >= 4) ? 1 : 0);
    end
    mrdy = 1;
    step();
    check("to_sticky", to_b, 1);
    check("to_cnt", cnt_b, 6);
    mrdy = 0;
    step();
    step();
    rst_n = 0;
    #1;
    check("arst_to", to_b, 0);
    check("arst_cnt", cnt_b, 0);
    check("arst_ctl", {hz_b.pc_wren, hz_b.p1_wren, hz_b.p1_flush, hz_b.p2_bubble, hz_b.p3_hold}, 5'b00010);
    idle();
    step();
    rst_n = 1;
    load_use(2, 2, 1, 1);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14 || i == 15 || i == 20) check($sformatf("sat_%0d", i), cnt_b, (i == 14) ? 14 : 15);
    end
    check("sat_a", cnt_a, 20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
